// File: rtl/dct_coef_reader.sv
// Streams a contiguous range of packed 8x12-bit DCT coefficient rows out of the output SRAM.
// Optional per-block nonzero statistic enabled by defining DCT_READER_NZSTAT_EN.
module dct_coef_reader #(
    parameter int BW    = 12,
    parameter int NCOEF = 8,
    parameter int AW    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [AW-1:0]         i_base_addr,
    input  logic [15:0]           i_num_words,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_nce,
    output logic                  o_mem_nwrt,
    output logic [AW-5:0]         o_mem_ra,
    output logic [3:0]            o_mem_ca,
    input  logic [NCOEF*BW-1:0]   i_mem_do,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NCOEF*BW-1:0]   o_data,
    output logic                  o_sob,
    output logic                  o_eob,
    output logic                  o_last,
    output logic [6:0]            o_nz_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [15:0]         left_q, left_d;
    logic [15:0]         num_q, num_d;
    logic [15:0]         k_q, k_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [NCOEF*BW-1:0] fifo_mem_q [2];

    logic pop;
    logic issue;
    logic is_last;
    logic room_ok;

    assign o_valid = (fifo_cnt_q != 2'd0);
    assign pop     = o_valid & i_ready;
    assign is_last = (k_q == num_q - 16'd1);
    // A slot is reserved for the read in flight, so the 2-deep FIFO can never overflow.
    assign room_ok = (3'(inflight_q) + 3'(fifo_cnt_q) - 3'(pop)) < 3'd2;
    assign issue   = (state_q == S_RUN) && (left_q != 16'd0) && room_ok;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        num_d      = num_q;
        k_d        = k_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fifo_cnt_d = fifo_cnt_q + 2'(inflight_q) - 2'(pop);

        if (pop) begin
            k_d      = k_q + 16'd1;
            rd_ptr_d = ~rd_ptr_q;
        end
        if (inflight_q) begin
            wr_ptr_d = ~wr_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    left_d  = i_num_words;
                    num_d   = i_num_words;
                    k_d     = 16'd0;
                    state_d = (i_num_words == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_q + AW'(1);
                    left_d = left_q - 16'd1;
                    if (left_q == 16'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && is_last) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            num_q      <= '0;
            k_q        <= '0;
            inflight_q <= 1'b0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            num_q      <= num_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; the occupancy count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            fifo_mem_q[wr_ptr_q] <= i_mem_do;
        end
    end

    assign o_data     = fifo_mem_q[rd_ptr_q];
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);
    assign o_mem_nce  = ~issue;
    assign o_mem_nwrt = 1'b1;
    assign o_mem_ra   = addr_q[AW-1:4];
    assign o_mem_ca   = addr_q[3:0];
    assign o_sob      = o_valid && (k_q[2:0] == 3'd0);
    assign o_eob      = o_valid && ((k_q[2:0] == 3'd7) || is_last);
    assign o_last     = o_valid && is_last;

`ifdef DCT_READER_NZSTAT_EN
    logic [6:0] nz_q, nz_d;
    logic [3:0] nz_word;

    always_comb begin
        nz_word = 4'd0;
        for (int j = 0; j < NCOEF; j++) begin
            nz_word = nz_word + 4'(o_data[j*BW +: BW] != '0);
        end
        nz_d = nz_q;
        if (pop) begin
            nz_d = o_eob ? 7'd0 : nz_q + 7'(nz_word);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            nz_q <= '0;
        end else begin
            nz_q <= nz_d;
        end
    end

    assign o_nz_count = o_valid ? nz_q + 7'(nz_word) : 7'd0;
`else
    assign o_nz_count = 7'd0;
`endif

endmodule

// File: tb/tb_dct_coef_reader.sv
// Self-checking bench for dct_coef_reader: SRAM model, randomized data and ready, index-based reference.
module tb_dct_coef_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [14:0] i_base_addr;
    logic [15:0] i_num_words;
    logic        o_busy, o_done, o_mem_nce, o_mem_nwrt;
    logic [10:0] o_mem_ra;
    logic [3:0]  o_mem_ca;
    logic [95:0] i_mem_do;
    logic        o_valid, i_ready;
    logic [95:0] o_data;
    logic        o_sob, o_eob, o_last;
    logic [6:0]  o_nz_count;

    int checks = 0;
    int errors = 0;

    logic [95:0] sram [0:32767];

    dct_coef_reader dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_num_words(i_num_words), .o_busy(o_busy), .o_done(o_done),
        .o_mem_nce(o_mem_nce), .o_mem_nwrt(o_mem_nwrt), .o_mem_ra(o_mem_ra),
        .o_mem_ca(o_mem_ca), .i_mem_do(i_mem_do), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_sob(o_sob), .o_eob(o_eob), .o_last(o_last),
        .o_nz_count(o_nz_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!o_mem_nce) i_mem_do <= sram[{o_mem_ra, o_mem_ca}];
    end

    function automatic logic [95:0] rand_word();
        logic [95:0] w;
        for (int j = 0; j < 8; j++) begin
            w[j*12 +: 12] = ($urandom_range(1) == 0) ? 12'd0 : 12'($urandom);
        end
        return w;
    endfunction

    function automatic int nz_of(input logic [95:0] w);
        int n = 0;
        for (int j = 0; j < 8; j++) if (w[j*12 +: 12] != 12'd0) n++;
        return n;
    endfunction

    function automatic logic [14:0] wa(input logic [14:0] base, input int idx);
        return 15'(int'(base) + idx);
    endfunction

    // Runs one transfer, checking every issue and handshake against the index-based model.
    task automatic run_xfer(input logic [14:0] base, input int num, input int ready_pct,
                            input bit mid_start, input int abort_at,
                            output int t_iss0, output int t_issn, output int t_val0,
                            output int t_hsn, output int t_done);
        int issued = 0, k = 0, pop_now, nz_exp, budget;
        bit fin = 0, stall_prev = 0;
        logic [95:0] prev_data = '0;
        logic [2:0]  exp_flags;
        t_iss0 = -1; t_issn = -1; t_val0 = -1; t_hsn = -1; t_done = -1;
        budget = num * 20 + 40;
        @(negedge clk);
        i_base_addr = base; i_num_words = 16'(num); i_start = 1'b1; i_ready = 1'b0;
        for (int cyc = 1; cyc <= budget && !fin; cyc++) begin
            @(negedge clk);
            i_start = mid_start && (cyc == 5);
            if (i_start) i_base_addr = base ^ 15'h1234;
            if (abort_at >= 0 && k == abort_at) begin
                reset = 1'b0;
                @(negedge clk); #1;
                checks++;
                if ({o_busy, o_done, o_valid, o_mem_nce, o_mem_ra, o_mem_ca, o_sob, o_eob, o_last, o_nz_count}
                    !== {4'b0001, 11'd0, 4'd0, 3'b000, 7'd0}) begin
                    errors++;
                    $display("FAIL abort_reset_outputs busy=%0b done=%0b valid=%0b nce=%0b ra=%h ca=%h", o_busy, o_done, o_valid, o_mem_nce, o_mem_ra, o_mem_ca);
                end
                reset = 1'b1;
                repeat (4) begin
                    @(negedge clk); #1;
                    checks++;
                    if (o_done !== 1'b0 || o_valid !== 1'b0 || o_mem_nce !== 1'b1) begin
                        errors++;
                        $display("FAIL abort_quiet done=%0b valid=%0b nce=%0b required 0 0 1", o_done, o_valid, o_mem_nce);
                    end
                end
                fin = 1;
            end else begin
                i_ready = ($urandom_range(99) < ready_pct);
                #1;
                pop_now = int'(o_valid & i_ready);
                checks++;
                if (o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got %0b required 1", cyc, o_busy);
                end
                if (!o_mem_nce) begin
                    if (t_iss0 < 0) t_iss0 = cyc;
                    t_issn = cyc;
                    checks++;
                    if (issued >= num) begin
                        errors++;
                        $display("FAIL extra_issue cyc=%0d issued=%0d required max %0d", cyc, issued, num);
                    end
                    checks++;
                    if ({o_mem_ra, o_mem_ca} !== wa(base, issued)) begin
                        errors++;
                        $display("FAIL issue_addr n=%0d got %h required %h", issued, {o_mem_ra, o_mem_ca}, wa(base, issued));
                    end
                    checks++;
                    if (issued - k - pop_now >= 2) begin
                        errors++;
                        $display("FAIL issue_while_full cyc=%0d outstanding=%0d required <2", cyc, issued - k - pop_now);
                    end
                    issued++;
                end
                if (o_valid) begin
                    if (t_val0 < 0) t_val0 = cyc;
                    if (stall_prev) begin
                        checks++;
                        if (o_data !== prev_data) begin
                            errors++;
                            $display("FAIL stall_stable k=%0d got %h required %h", k, o_data, prev_data);
                        end
                    end
                    if (i_ready) begin
                        checks++;
                        if (k >= num) begin
                            errors++;
                            $display("FAIL extra_word k=%0d required max %0d", k, num);
                        end else begin
                            if (o_data !== sram[wa(base, k)]) begin
                                errors++;
                                $display("FAIL data k=%0d got %h required %h", k, o_data, sram[wa(base, k)]);
                            end
                            exp_flags = {k % 8 == 0, (k % 8 == 7) || (k == num - 1), k == num - 1};
                            checks++;
                            if ({o_sob, o_eob, o_last} !== exp_flags) begin
                                errors++;
                                $display("FAIL flags k=%0d got %b required %b", k, {o_sob, o_eob, o_last}, exp_flags);
                            end
                            nz_exp = 0;
`ifdef DCT_READER_NZSTAT_EN
                            for (int j = k - k % 8; j <= k; j++) nz_exp += nz_of(sram[wa(base, j)]);
`endif
                            if (exp_flags[1]) begin
                                checks++;
                                if (o_nz_count !== 7'(nz_exp)) begin
                                    errors++;
                                    $display("FAIL nz_count k=%0d got %0d required %0d", k, o_nz_count, nz_exp);
                                end
                            end
                        end
                        k++;
                        t_hsn = cyc;
                    end
                end
                stall_prev = o_valid && !i_ready;
                prev_data  = o_data;
                if (o_done) begin
                    t_done = cyc;
                    checks++;
                    if (k != num || issued != num) begin
                        errors++;
                        $display("FAIL done_counts words=%0d issued=%0d required %0d", k, issued, num);
                    end
                    fin = 1;
                end
            end
        end
        i_start = 1'b0;
        if (!fin) begin
            errors++;
            $display("FAIL timeout base=%h num=%0d words=%0d", base, num, k);
        end else if (abort_at < 0) begin
            @(negedge clk); #1;
            checks++;
            if (o_busy !== 1'b0 || o_done !== 1'b0) begin
                errors++;
                $display("FAIL post_done busy=%0b done=%0b required 0 0", o_busy, o_done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({o_busy, o_done, o_valid, o_mem_nce, o_mem_nwrt, o_mem_ra, o_mem_ca, o_sob, o_eob, o_last, o_nz_count}
            !== {5'b00011, 11'd0, 4'd0, 3'b000, 7'd0}) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b done=%0b valid=%0b nce=%0b nwrt=%0b ra=%h ca=%h", o_busy, o_done, o_valid, o_mem_nce, o_mem_nwrt, o_mem_ra, o_mem_ca);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int a, b, c, d, e;
        run_xfer(15'h0000, 8, 100, 0, -1, a, b, c, d, e);
        checks++;
        if (a != 1 || b != 8 || c != 3 || d != 10 || e != 11) begin
            errors++;
            $display("FAIL basic_timing iss=%0d..%0d valid=%0d..%0d done=%0d required 1..8 3..10 11", a, b, c, d, e);
        end
    endtask

    task automatic test_stall();
        int a, b, c, d, e;
        run_xfer(15'($urandom), 16, 55, 1, -1, a, b, c, d, e);
    endtask

    task automatic test_wrap();
        int a, b, c, d, e;
        run_xfer(15'h7FFE, 4, 100, 0, -1, a, b, c, d, e);
        run_xfer(15'h7FFC, 9, 60, 0, -1, a, b, c, d, e);
    endtask

    task automatic test_partial();
        int a, b, c, d, e, placed, pos;
        logic [14:0] base = 15'h0420;
        logic [95:0] w;
        for (int i = 8; i < 12; i++) sram[wa(base, i)] = '0;
        placed = 0;
        while (placed < 5) begin
            pos = $urandom_range(31);
            w = sram[wa(base, 8 + pos / 8)];
            if (w[(pos % 8) * 12 +: 12] == 12'd0) begin
                w[(pos % 8) * 12 +: 12] = 12'($urandom_range(4095, 1));
                sram[wa(base, 8 + pos / 8)] = w;
                placed++;
            end
        end
        run_xfer(base, 12, 80, 0, -1, a, b, c, d, e);
    endtask

    task automatic test_zero();
        int a, b, c, d, e;
        run_xfer(15'h1234, 0, 100, 0, -1, a, b, c, d, e);
        checks++;
        if (a != -1 || c != -1 || e != 1) begin
            errors++;
            $display("FAIL zero_len first_issue=%0d first_valid=%0d done=%0d required -1 -1 1", a, c, e);
        end
    endtask

    task automatic test_abort();
        int a, b, c, d, e;
        run_xfer(15'h0100, 8, 100, 0, 3, a, b, c, d, e);
        run_xfer(15'h0300, 8, 100, 0, -1, a, b, c, d, e);
        checks++;
        if (a != 1 || e != 11) begin
            errors++;
            $display("FAIL restart_timing first_issue=%0d done=%0d required 1 11", a, e);
        end
    endtask

    task automatic test_back_to_back();
        int a, b, c, d, e;
        for (int t = 0; t < 6; t++) begin
            run_xfer(15'($urandom), int'($urandom_range(20, 1)), int'($urandom_range(100, 30)), 0, -1, a, b, c, d, e);
        end
    endtask

    initial begin
        reset = 1'b0; i_start = 1'b0; i_ready = 1'b0;
        i_base_addr = '0; i_num_words = '0; i_mem_do = '0;
        for (int i = 0; i < 32768; i++) sram[i] = rand_word();
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_partial();
        test_zero();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dct_coef_reader.md
Name: dct_coef_reader

Overview:
Read-back engine for the 2D-DCT output SRAM (32768x96). It fetches a contiguous range of packed coefficient rows from the memory the DCT pipeline writes. Each row is 8 coefficients of 12 bits. It streams the rows out over a valid/ready interface with 8x8-block framing flags. It sits between the output SRAM read port and downstream consumers (quantizer, host dump, IDCT).

Parameters:
BW, 12, coefficient width in bits
NCOEF, 8, coefficients per SRAM word (data width = NCOEF*BW = 96)
AW, 15, SRAM word address width (RA = addr[14:4], 11 b; CA = addr[3:0], 4 b)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
i_start  input  1  start pulse; sampled only when idle
i_base_addr  input  15  first word address, latched on accepted start
i_num_words  input  16  words to read, 0..32768, latched on accepted start
o_busy  output  1  high from accepted start until o_done
o_done  output  1  one-cycle completion pulse
o_mem_nce  output  1  SRAM chip enable, active-low; low only in a read-issue cycle
o_mem_nwrt  output  1  SRAM write enable, active-low; constant 1
o_mem_ra  output  11  SRAM row address
o_mem_ca  output  4  SRAM column address
i_mem_do  input  96  SRAM read data, valid the cycle after the issue cycle
o_valid  output  1  stream data valid
i_ready  input  1  stream consumer ready
o_data  output  96  coefficient row; coef j at [12j+11:12j]
o_sob  output  1  start of block: word index k%8==0
o_eob  output  1  end of block: k%8==7 or last word
o_last  output  1  final word of the transfer
o_nz_count  output  7  nonzero coefficients in the block (see Optional Feature)

Behaviour:
- Reset (reset==0 at posedge): FSM IDLE; FIFO flushed; in-flight read discarded. o_busy=0, o_done=0, o_valid=0, o_mem_nce=1, o_mem_ra=0, o_mem_ca=0, o_sob/o_eob/o_last=0, o_nz_count=0. Reset mid-transfer aborts with no o_done.
- FSM states:
  - IDLE: i_start=1 latches base and count, then goes to RUN; if count==0, goes to DONE instead.
  - RUN: issues reads until all are issued, then goes to DRAIN.
  - DRAIN: waits for the last handshake, then goes to DONE.
  - DONE: one cycle with o_done=1, then back to IDLE.
- i_start is ignored outside IDLE. o_busy=1 in RUN, DRAIN and DONE.
- Read issue: in issue cycle t, o_mem_nce=0 and address = base+n (n = issue index). i_mem_do is captured at the end of cycle t+1 into a 2-entry output FIFO.
- Issue is allowed only when inflight + occupancy − pop_this_cycle < 2. The FIFO can never overflow. With i_ready held high, throughput is 1 word/cycle.
- Address arithmetic is modulo 2^15: 0x7FFF+1 = 0x0000.
- Stream: o_valid = FIFO not empty. Handshake = o_valid & i_ready. o_data and the flags are stable while o_valid & ~i_ready. No word is lost or duplicated.
- Flags are computed from output index k, counted per handshake.
- Latency: start in cycle 0, first issue in cycle 1, first o_valid in cycle 3. o_done is asserted the cycle after the last handshake.
- Partial final block: o_eob is asserted on the last word.

Optional Feature:
Macro DCT_READER_NZSTAT_EN.
- Defined: a per-block counter sums the nonzero 12-bit coefficients over the block's words (max 64). It clears after each eob handshake. o_nz_count shows the running total including the current word, and is meaningful when o_valid & o_eob.
- Undefined: no counter logic; o_nz_count is tied to 0.

Test Plan:
- base=0x0000, num=8, i_ready=1 → addresses 0..7 issued in cycles 1..8; o_valid in cycles 3..10; o_sob on word 0; o_eob and o_last on word 7; o_done in cycle 11; data matches preload.
- num=16, i_ready toggled pseudo-randomly → 16 words in order, no duplicates. o_mem_nce stays 1 whenever the FIFO is full with a pending stall. o_data is stable during stalls.
- base=0x7FFE, num=4 → RA/CA sequence 0x7FF/E, 0x7FF/F, 0x000/0, 0x000/1.
- num=12 → o_eob on words 7 and 11, o_sob on words 0 and 8, o_last on word 11. With NZSTAT_EN and block 1 holding 5 nonzero coefs, o_nz_count=5 at word 11.
- num=0 → no o_mem_nce low and no o_valid; o_done one cycle after accept. i_start pulsed mid-transfer is ignored.
- reset low at word 3 of 8 → all outputs return to reset values the next cycle with no o_done. A new start afterwards runs cleanly from its own base address.
